// File: rtl/i2c_eeprom_slave_fe_pkg.sv
// i2c_eeprom_pkg: shared widths, default device address and FSM state encoding
package i2c_eeprom_pkg;
  localparam int PAGE_W = 5;
  localparam int OFF_W = 3;
  localparam int BYTE_W = 8;
  localparam logic [6:0] DEV_ADDR_DEF = 7'h50;
  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP
  } state_t;
endpackage

// File: rtl/i2c_eeprom_slave_fe_if.sv
// i2c_eeprom_slave_fe_if: I2C pads plus address-counter and memory-array strobes
interface i2c_eeprom_slave_fe_if;
  import i2c_eeprom_pkg::*;
  logic scl_i, sda_i, sda_oe, addr_load, addr_inc, mem_wr, busy;
  logic [BYTE_W-1:0] addr_o, mem_wr_data, mem_rd_data;
  modport slave(input scl_i, sda_i, mem_rd_data,
                output sda_oe, addr_load, addr_o, addr_inc, mem_wr, mem_wr_data, busy);
  modport master(output scl_i, sda_i, mem_rd_data,
                 input sda_oe, addr_load, addr_o, addr_inc, mem_wr, mem_wr_data, busy);
endinterface

// File: rtl/i2c_eeprom_slave_fe_sync.sv
// i2c_bus_sync_edge: SCL/SDA synchroniser with SCL edge and START/STOP pulses
module i2c_bus_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda,
  output logic start,
  output logic stop
);
  localparam int N = SYNC_STAGES;
  logic [N-1:0] scl_s, sda_s;
  logic scl_new, scl_old, sda_new, sda_old;
  // shift raw pads through the synchroniser chain; idle bus level is high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_s <= '1;
      sda_s <= '1;
    end else begin
      scl_s <= {scl_s[N-2:0], scl_i};
      sda_s <= {sda_s[N-2:0], sda_i};
    end
  assign scl_new = scl_s[N-2];
  assign scl_old = scl_s[N-1];
  assign sda_new = sda_s[N-2];
  assign sda_old = sda_s[N-1];
  assign scl_rise = scl_new & ~scl_old;
  assign scl_fall = ~scl_new & scl_old;
  assign sda = sda_new;
  assign start = scl_new & scl_old & sda_old & ~sda_new;
  assign stop = scl_new & scl_old & ~sda_old & sda_new;
endmodule

// File: rtl/i2c_eeprom_slave_fe.sv
// i2c_eeprom_slave_fe: I2C slave protocol front end for a 24C02-style EEPROM
module i2c_eeprom_slave_fe
  import i2c_eeprom_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  i2c_eeprom_slave_fe_if.slave bus
);
  logic scl_rise, scl_fall, sda, start, stop;
  state_t st;
  logic [2:0] cnt;
  logic [BYTE_W-1:0] sr, rx;
  logic rd_ld, last, match;
  i2c_bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .scl_i(bus.scl_i), .sda_i(bus.sda_i),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .sda(sda), .start(start), .stop(stop)
  );
  assign rx = {sr[BYTE_W-2:0], sda};
  assign last = cnt == 3'd7;
  assign match = rx[7:1] == DEV_ADDR;
  // protocol FSM; addr_inc after a write trails mem_wr by exactly one clk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      sr <= '0;
      rd_ld <= 1'b0;
      bus.sda_oe <= 1'b0;
      bus.busy <= 1'b0;
      bus.addr_load <= 1'b0;
      bus.addr_o <= '0;
      bus.addr_inc <= 1'b0;
      bus.mem_wr <= 1'b0;
      bus.mem_wr_data <= '0;
    end else begin
      bus.addr_load <= 1'b0;
      bus.mem_wr <= 1'b0;
      bus.addr_inc <= bus.mem_wr;
      if (start) begin
        st <= DEV;
        cnt <= '0;
        rd_ld <= 1'b0;
        bus.sda_oe <= 1'b0;
      end else if (stop) begin
        st <= IDLE;
        bus.sda_oe <= 1'b0;
        bus.busy <= 1'b0;
      end else begin
        case (st)
          DEV: if (scl_rise) begin
            sr <= rx;
            cnt <= cnt + 3'd1;
            if (last) begin
              st <= match ? DEV_ACK : WAIT_STOP;
              bus.busy <= match;
            end
          end
          WADDR: if (scl_rise) begin
            sr <= rx;
            cnt <= cnt + 3'd1;
            if (last) begin
              bus.addr_o <= rx;
              bus.addr_load <= 1'b1;
              st <= WADDR_ACK;
            end
          end
          WDATA: if (scl_rise) begin
            sr <= rx;
            cnt <= cnt + 3'd1;
            if (last) begin
              bus.mem_wr_data <= rx;
              bus.mem_wr <= 1'b1;
              st <= WDATA_ACK;
            end
          end
          DEV_ACK, WADDR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!bus.sda_oe) bus.sda_oe <= 1'b1;
            else if (st == DEV_ACK && sr[0]) begin
              st <= RDATA;
              sr <= bus.mem_rd_data;
              bus.sda_oe <= ~bus.mem_rd_data[7];
              cnt <= '0;
            end else begin
              bus.sda_oe <= 1'b0;
              st <= st == DEV_ACK ? WADDR : WDATA;
            end
          end
          RDATA: if (scl_fall) begin
            if (rd_ld) begin
              rd_ld <= 1'b0;
              sr <= bus.mem_rd_data;
              bus.sda_oe <= ~bus.mem_rd_data[7];
              cnt <= '0;
            end else if (last) begin
              bus.sda_oe <= 1'b0;
              st <= RD_MACK;
            end else begin
              sr <= {sr[BYTE_W-2:0], 1'b0};
              bus.sda_oe <= ~sr[6];
              cnt <= cnt + 3'd1;
            end
          end
          RD_MACK: if (scl_rise) begin
            if (!sda) begin
              bus.addr_inc <= 1'b1;
              rd_ld <= 1'b1;
              st <= RDATA;
            end else begin
              st <= WAIT_STOP;
              bus.busy <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_i2c_eeprom_slave_fe.sv
// tb_i2c_eeprom_slave_fe: randomized I2C master with scoreboard against an EEPROM reference model
module tb_i2c_eeprom_slave_fe;
  localparam int Q = 50;
  typedef struct {
    int k;
    logic [7:0] d;
    bit aw;
  } ev_t;
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, sda_m = 1'b1, seed = 1'b1;
  logic [7:0] emu[256];
  logic [7:0] ctr;
  logic [7:0] ref_mem[256];
  logic [7:0] ref_ptr = 8'h00;
  logic [7:0] wbuf[8];
  logic wr_prev = 1'b0;
  ev_t q[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  i2c_eeprom_slave_fe_if bus ();
  i2c_eeprom_slave_fe dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.scl_i = scl;
  assign bus.sda_i = sda_m & ~bus.sda_oe;
  assign bus.mem_rd_data = emu[ctr];
  // downstream address counter and array driven by the DUT strobes
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 256; i++) emu[i] <= ref_mem[i];
      ctr <= 8'h00;
    end else begin
      if (bus.mem_wr) emu[ctr] <= bus.mem_wr_data;
      if (bus.addr_load) ctr <= bus.addr_o;
      else if (bus.addr_inc) ctr <= (ctr & 8'hF8) | ((ctr + 8'd1) & 8'h07);
    end
  end
  function automatic logic [7:0] nxt(input logic [7:0] p);
    return (p & 8'hF8) | ((p + 8'd1) & 8'h07);
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic pop(input int k, input logic [7:0] d);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_strobe: got kind %0d data %0h expected none at %0t", k, d, $time);
    end else begin
      e = q.pop_front();
      chk("ev_kind", k, e.k);
      if (k != 2) chk("ev_data", {24'h0, d}, {24'h0, e.d});
      else if (e.aw) chk("inc_after_wr", {31'h0, wr_prev}, 1);
    end
  endtask
  // scoreboard monitor: every strobe must match the next expected event
  always @(negedge clk) begin
    if (rst_n) begin
      chk("strobe_excl", {30'h0, bus.addr_load & bus.addr_inc, bus.mem_wr & bus.addr_inc}, 0);
      if (bus.addr_load) pop(0, bus.addr_o);
      if (bus.mem_wr) pop(1, bus.mem_wr_data);
      if (bus.addr_inc) pop(2, 8'h00);
    end
    wr_prev = bus.mem_wr;
  end
  task automatic bit_io(input logic b, output logic r);
    #Q sda_m = b;
    #Q scl = 1'b1;
    #Q r = bus.sda_i;
    #Q scl = 1'b0;
  endtask
  task automatic i2c_start();
    #Q sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
  endtask
  task automatic i2c_stop();
    #Q sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, r);
    chk("ack", {31'h0, r}, {31'h0, ~ack});
  endtask
  task automatic recv_byte(input logic [7:0] e, input logic mack);
    logic r;
    logic [7:0] v;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      v[i] = r;
    end
    bit_io(~mack, r);
    chk("rd_data", {24'h0, v}, {24'h0, e});
  endtask
  task automatic do_write(input logic [7:0] a, input int n);
    i2c_start();
    send_byte(8'hA0, 1'b1);
    chk("busy_match", {31'h0, bus.busy}, 1);
    q.push_back('{0, a, 1'b0});
    send_byte(a, 1'b1);
    ref_ptr = a;
    for (int i = 0; i < n; i++) begin
      q.push_back('{1, wbuf[i], 1'b0});
      q.push_back('{2, 8'h00, 1'b1});
      send_byte(wbuf[i], 1'b1);
      ref_mem[ref_ptr] = wbuf[i];
      ref_ptr = nxt(ref_ptr);
    end
    i2c_stop();
    chk("busy_stop", {31'h0, bus.busy}, 0);
  endtask
  task automatic do_read(input int n, input bit use_addr, input logic [7:0] a);
    i2c_start();
    if (use_addr) begin
      send_byte(8'hA0, 1'b1);
      q.push_back('{0, a, 1'b0});
      send_byte(a, 1'b1);
      ref_ptr = a;
      i2c_start();
    end
    send_byte(8'hA1, 1'b1);
    chk("busy_rd", {31'h0, bus.busy}, 1);
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) q.push_back('{2, 8'h00, 1'b0});
      recv_byte(ref_mem[ref_ptr], i < n - 1);
      if (i < n - 1) ref_ptr = nxt(ref_ptr);
    end
    chk("busy_nack", {31'h0, bus.busy}, 0);
    chk("oe_nack", {31'h0, bus.sda_oe}, 0);
    i2c_stop();
  endtask
  task automatic chk_zero(input string nm);
    chk(nm, {11'h0, bus.sda_oe, bus.busy, bus.addr_load, bus.addr_inc, bus.mem_wr,
             bus.addr_o, bus.mem_wr_data}, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic r;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    repeat (4) @(posedge clk);
    #1 chk_zero("reset_outs");
    seed = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    wbuf[0] = 8'h5A;
    do_write(8'h13, 1);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(8'h1E, 3);
    do_read(2, 1'b0, 8'h00);
    wbuf[0] = 8'hC3;
    do_write(8'h40, 1);
    do_read(2, 1'b1, 8'h40);
    i2c_start();
    send_byte(8'hA4, 1'b0);
    chk("busy_mismatch", {31'h0, bus.busy}, 0);
    send_byte(8'($urandom), 1'b0);
    wbuf[0] = 8'($urandom);
    do_write(8'($urandom), 1);
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        do_write(8'($urandom), int'($urandom_range(6, 1)));
      end else do_read(int'($urandom_range(4, 1)), bit'($urandom_range(1, 0)), 8'($urandom));
    end
    i2c_start();
    send_byte(8'hA0, 1'b1);
    q.push_back('{0, 8'h25, 1'b0});
    send_byte(8'h25, 1'b1);
    ref_ptr = 8'h25;
    for (int i = 0; i < 4; i++) bit_io(1'($urandom), r);
    i2c_stop();
    chk("busy_stop_mid", {31'h0, bus.busy}, 0);
    do_read(1, 1'b0, 8'h00);
    wbuf[0] = 8'h00;
    do_write(8'h60, 1);
    i2c_start();
    send_byte(8'hA0, 1'b1);
    q.push_back('{0, 8'h60, 1'b0});
    send_byte(8'h60, 1'b1);
    ref_ptr = 8'h60;
    i2c_start();
    send_byte(8'hA1, 1'b1);
    for (int i = 0; i < 3; i++) bit_io(1'b1, r);
    #Q chk("oe_before_rst", {31'h0, bus.sda_oe}, 1);
    rst_n = 1'b0;
    #1 chk_zero("abort_outs");
    repeat (4) @(posedge clk);
    rst_n = 1'b1;
    i2c_stop();
    do_read(1, 1'b0, 8'h00);
    repeat (20) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
